// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Latency: clock line pulled low the cycle after accept; outputs registered, line inputs seen 2 cycles late.
// Backpressure: tx_ready high only when idle; requests made while busy are dropped, not queued.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state;
    logic [9:0]    frame;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          clk_fall;

    assign clk_fall = clk_prev & ~clk_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            frame      <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_prev   <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            tx_ready   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    to_cnt     <= '0;
                    bit_cnt    <= '0;
                    state      <= SEND;
                end
                default: begin
                    // The timeout covers the whole device-clocked phase, even if no edge ever arrives.
                    if (to_cnt == TO_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        busy       <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        case (state)
                            SEND: begin
                                if (clk_fall) begin
                                    ps2_dat_oe <= ~frame[0];
                                    frame      <= {1'b0, frame[9:1]};
                                    bit_cnt    <= bit_cnt + 4'd1;
                                    if (bit_cnt == 4'd9) state <= ACK;
                                end
                            end
                            ACK: begin
                                if (clk_fall) begin
                                    if (dat_s2) begin
                                        ps2_dat_oe <= 1'b0;
                                        busy       <= 1'b0;
                                        tx_error   <= 1'b1;
                                        state      <= IDLE;
                                    end else begin
                                        state <= WAIT_IDLE;
                                    end
                                end
                            end
                            WAIT_IDLE: begin
                                if (clk_s2 && dat_s2) begin
                                    busy    <= 1'b0;
                                    tx_done <= 1'b1;
                                    state   <= IDLE;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
